log_scale_axis: RTL and testbench

Parametrised streaming log2 magnitude converter for the spectrum display path. It sits between the FFT magnitude-squared stage and the display/bin buffer. Each input beat is converted to a fixed-point log2 value with an integer part and a LUT-refined fractional part. A programmable offset is subtracted with a floor at zero, and the peak value of each frame is reported. The stream interface is valid/ready with full backpressure, so the block can feed a stalling consumer without losing beats.

---
 rtl/log_scale_pkg.sv | 42 ++++
 rtl/leading_one_detect.sv | 23 ++
 rtl/log_scale_axis.sv | 158 +++++++++++++++
 tb/tb_log_scale_axis.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/log_scale_pkg.sv
// log_scale_pkg: shared constants and elaboration-time helpers for log_scale_axis.
// Latency: n/a (functions evaluated at elaboration only).
// Backpressure: n/a.
// Contents: out_width() gives the output width, lut_entry() gives one fractional LUT entry.
package log_scale_pkg;

    // Fractional bits of the fixed-point working value used by lut_entry().
    localparam int LUT_CALC_P = 30;

    // Output width is the integer part (enough bits to hold the leading-one
    // index) followed by the fractional part.
    function automatic int out_width(input int in_w, input int frac_w);
        return $clog2(in_w) + frac_w;
    endfunction

    // round(log2(1 + idx/2^lut_bits) * 2^frac_w), saturated to 2^frac_w-1.
    // Uses the square-and-compare method in integer arithmetic so no real
    // math is needed: every squaring doubles the log, and a result >= 2
    // yields a 1 bit. One extra bit is produced so it can be rounded.
    function automatic int lut_entry(input int idx, input int lut_bits, input int frac_w);
        logic [63:0] y;
        int          bits;
        int          val;
        y    = ((64'd1 << lut_bits) + 64'(idx)) << LUT_CALC_P;
        y    = y >> lut_bits;
        bits = 0;
        for (int k = 0; k < frac_w + 1; k++) begin
            y    = (y * y) >> LUT_CALC_P;
            bits = bits * 2;
            if (y >= (64'd2 << LUT_CALC_P)) begin
                bits = bits + 1;
                y    = y >> 1;
            end
        end
        val = (bits + 1) >> 1;
        if (val > (1 << frac_w) - 1) begin
            val = (1 << frac_w) - 1;
        end
        return val;
    endfunction

endpackage

// File: rtl/leading_one_detect.sv
// leading_one_detect: combinational priority encoder returning the index of the highest set bit.
// Latency: 0 cycles (pure combinational).
// Backpressure: n/a.
// Ports: vec (W-bit input), pos ($clog2(W)-bit index, 0 when vec is all zero).
module leading_one_detect #(
    parameter  int W  = 32,
    localparam int OW = (W > 1) ? $clog2(W) : 1
) (
    input  logic [W-1:0]  vec,
    output logic [OW-1:0] pos
);

    // Ascending scan: the last set bit seen is the most significant one.
    always_comb begin
        pos = '0;
        for (int i = 0; i < W; i++) begin
            if (vec[i]) begin
                pos = OW'(i);
            end
        end
    end

endmodule

// File: rtl/log_scale_axis.sv
// log_scale_axis: streaming log2 magnitude converter with offset subtraction and per-frame peak.
// Latency: 3 cycles from input handshake to out_valid when not stalled; 1 beat/cycle throughput.
// Backpressure: whole pipeline holds when out_valid & ~out_ready; in_ready drops in the same cycle.
// Ports: clk/rst (sync, active-high); in_data/in_valid/in_last/in_ready input stream;
//        cfg_offset static offset; out_data/out_valid/out_last/out_ready output stream;
//        peak_data/peak_valid per-frame maximum with a one-cycle update pulse.
module log_scale_axis
    import log_scale_pkg::*;
#(
    parameter  int IN_W     = 32,
    parameter  int FRAC_W   = 3,
    parameter  int LUT_BITS = 4,
    localparam int INT_W    = $clog2(IN_W),
    localparam int OUT_W    = out_width(IN_W, FRAC_W)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    input  logic [OUT_W-1:0] cfg_offset,
    output logic [OUT_W-1:0] out_data,
    output logic             out_valid,
    output logic             out_last,
    input  logic             out_ready,
    output logic [OUT_W-1:0] peak_data,
    output logic             peak_valid
);

    localparam int LUT_DEPTH = 1 << LUT_BITS;

    // Single enable for every stage: bubbles are not squeezed out, so the
    // pipe advances only when the output register is empty or being taken.
    logic en;
    assign en       = out_ready | ~out_valid;
    assign in_ready = en;

    // Fractional-part table, fixed at elaboration.
    logic [FRAC_W-1:0] lut [LUT_DEPTH];
    for (genvar g = 0; g < LUT_DEPTH; g++) begin : g_lut
        assign lut[g] = FRAC_W'(lut_entry(g, LUT_BITS, FRAC_W));
    end

    // ---------------- Stage 1: exponent and normalisation ----------------
    logic [INT_W-1:0] lead;
    logic [IN_W-1:0]  shifted;

    leading_one_detect #(
        .W (IN_W)
    ) u_lod (
        .vec (in_data),
        .pos (lead)
    );

    // Moves the leading one to the MSB; zero input stays zero (lead = 0).
    assign shifted = in_data << (INT_W'(IN_W - 1) - lead);

    logic             s1_vld;
    logic             s1_last;
    logic [INT_W-1:0] s1_exp;
    logic [IN_W-1:0]  s1_norm;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld  <= 1'b0;
            s1_last <= 1'b0;
            s1_exp  <= '0;
            s1_norm <= '0;
        end else if (en) begin
            s1_vld  <= in_valid;
            s1_last <= in_last;
            if (in_valid) begin
                s1_exp  <= lead;
                s1_norm <= shifted;
            end
        end
    end

    // ---------------- Stage 2: LUT refinement ----------------
    // Mantissa bits below the leading one, zero-padded so narrow inputs
    // still yield a full LUT_BITS address.
    logic [IN_W-2+LUT_BITS:0] mant_ext;
    logic [LUT_BITS-1:0]      idx;

    assign mant_ext = {s1_norm[IN_W-2:0], {LUT_BITS{1'b0}}};
    assign idx      = mant_ext[IN_W-2+LUT_BITS -: LUT_BITS];

    // The implied leading one and the mantissa bits past the LUT address
    // carry no information for the result.
    logic unused_bits;
    assign unused_bits = ^{s1_norm[IN_W-1], mant_ext[IN_W-2:0]};

    logic             s2_vld;
    logic             s2_last;
    logic [OUT_W-1:0] s2_raw;

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_vld  <= 1'b0;
            s2_last <= 1'b0;
            s2_raw  <= '0;
        end else if (en) begin
            s2_vld  <= s1_vld;
            s2_last <= s1_last;
            if (s1_vld) begin
                s2_raw <= {s1_exp, lut[idx]};
            end
        end
    end

    // ---------------- Stage 3: offset with floor at zero ----------------
    logic [OUT_W-1:0] sub_res;
    assign sub_res = (s2_raw >= cfg_offset) ? (s2_raw - cfg_offset) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
        end else if (en) begin
            out_valid <= s2_vld;
            out_last  <= s2_last;
            if (s2_vld) begin
                out_data <= sub_res;
            end
        end
    end

    // ---------------- Peak tracking on output handshakes ----------------
    logic             out_hs;
    logic [OUT_W-1:0] acc;
    logic [OUT_W-1:0] frame_max;

    assign out_hs    = out_valid & out_ready;
    assign frame_max = (acc > out_data) ? acc : out_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            acc        <= '0;
            peak_data  <= '0;
            peak_valid <= 1'b0;
        end else begin
            peak_valid <= 1'b0;
            if (out_hs) begin
                if (out_last) begin
                    // Close the frame; the last beat itself takes part.
                    peak_data  <= frame_max;
                    peak_valid <= 1'b1;
                    acc        <= '0;
                end else begin
                    acc <= frame_max;
                end
            end
        end
    end

endmodule

// File: tb/tb_log_scale_axis.sv
// tb_log_scale_axis: directed and randomised-backpressure bench for log_scale_axis.
// Latency: n/a.
// Backpressure: drives out_ready both steady and randomly toggling.
module tb_log_scale_axis;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_last;
    logic        in_ready;
    logic [7:0]  cfg_offset;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_last;
    logic        out_ready;
    logic [7:0]  peak_data;
    logic        peak_valid;

    always #5 clk = ~clk;

    log_scale_axis dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .cfg_offset (cfg_offset),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_last   (out_last),
        .out_ready  (out_ready),
        .peak_data  (peak_data),
        .peak_valid (peak_valid)
    );

    // Hand-derived round(log2(1+i/16)*8), saturated at 7.
    localparam logic [2:0] LUT_REF [16] = '{3'd0, 3'd1, 3'd1, 3'd2, 3'd3, 3'd3, 3'd4, 3'd4,
                                            3'd5, 3'd5, 3'd6, 3'd6, 3'd6, 3'd7, 3'd7, 3'd7};

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] ref_log(input logic [31:0] x, input logic [7:0] off);
        int          e;
        logic [31:0] m;
        logic [3:0]  li;
        logic [7:0]  raw;
        e = 0;
        for (int i = 0; i < 32; i++) begin
            if (x[i]) e = i;
        end
        m   = x << (31 - e);
        li  = m[30:27];
        raw = {e[4:0], LUT_REF[li]};
        return (raw >= off) ? raw - off : 8'd0;
    endfunction

    // Directed stream vectors and the peak expectation derived from them.
    logic [31:0] q_in   [$];
    logic        q_last [$];
    logic [7:0]  q_exp  [$];
    logic [7:0]  m_acc  = 8'd0;
    logic [7:0]  m_peak = 8'd0;
    logic        m_pv   = 1'b0;

    task automatic add(input logic [31:0] d, input logic l, input logic [7:0] e);
        q_in.push_back(d);
        q_last.push_back(l);
        q_exp.push_back(e);
    endtask

    // Feeds the queued vectors back-to-back with out_ready=1; each output must
    // appear exactly 3 cycles after its input was presented.
    task automatic stream(input string name);
        int         n;
        logic [7:0] mx;
        n = q_in.size();
        for (int t = 0; t <= n + 2; t++) begin
            in_valid = (t < n);
            if (t < n) begin
                in_data = q_in[t];
                in_last = q_last[t];
            end else begin
                in_data = '0;
                in_last = 1'b0;
            end
            tick();
            check($sformatf("%s out_valid t%0d", name, t), out_valid, (t >= 2 && t - 2 < n));
            check($sformatf("%s peak_valid t%0d", name, t), peak_valid, m_pv);
            if (m_pv) check($sformatf("%s peak_data t%0d", name, t), peak_data, m_peak);
            m_pv = 1'b0;
            if (t >= 2 && t - 2 < n) begin
                check($sformatf("%s out_data #%0d", name, t - 2), out_data, q_exp[t-2]);
                check($sformatf("%s out_last #%0d", name, t - 2), out_last, q_last[t-2]);
                mx = (m_acc > q_exp[t-2]) ? m_acc : q_exp[t-2];
                if (q_last[t-2]) begin
                    m_peak = mx;
                    m_acc  = 8'd0;
                    m_pv   = 1'b1;
                end else begin
                    m_acc = mx;
                end
            end
        end
        q_in.delete();
        q_last.delete();
        q_exp.delete();
    endtask

    logic [8:0] sb [$];
    int         sent;
    int         recv;
    int         cyc;
    logic       stalled;
    logic [7:0] held_d;
    logic       held_l;

    initial begin
        rst        = 1'b1;
        in_data    = '0;
        in_valid   = 1'b0;
        in_last    = 1'b0;
        cfg_offset = 8'h00;
        out_ready  = 1'b1;
        repeat (3) tick();
        check("reset out_valid", out_valid, 0);
        check("reset out_data", out_data, 0);
        check("reset out_last", out_last, 0);
        check("reset peak_valid", peak_valid, 0);
        check("reset peak_data", peak_data, 0);
        check("reset in_ready", in_ready, 1);
        rst = 1'b0;

        // Basic conversion, frame closed by the zero beat (peak 0xFF).
        add(32'h1, 1'b0, 8'h00);
        add(32'h2, 1'b0, 8'h08);
        add(32'h3, 1'b0, 8'h0D);
        add(32'h8000_0000, 1'b0, 8'hF8);
        add(32'hFFFF_FFFF, 1'b0, 8'hFF);
        add(32'h0, 1'b1, 8'h00);
        stream("basic");
        check("basic peak", peak_data, 8'hFF);

        // Offset with floor at zero.
        cfg_offset = 8'h10;
        add(32'h0001_0000, 1'b0, 8'h70);
        add(32'h2, 1'b1, 8'h00);
        stream("offset");
        check("offset peak", peak_data, 8'h70);

        // Four-beat frame, then a single-beat frame.
        cfg_offset = 8'h00;
        add(32'h10, 1'b0, 8'h20);
        add(32'h0004_0000, 1'b0, 8'h90);
        add(32'h100, 1'b0, 8'h40);
        add(32'h4, 1'b1, 8'h10);
        stream("frame4");
        check("frame4 peak", peak_data, 8'h90);
        cfg_offset = 8'h10;
        add(32'h6, 1'b1, 8'h05);
        stream("frame1");
        check("frame1 peak", peak_data, 8'h05);

        // Fill the pipe, stall 5 cycles, then drain.
        cfg_offset = 8'h00;
        in_valid   = 1'b1;
        in_last    = 1'b0;
        in_data    = 32'h4;  tick();
        in_data    = 32'h8;  tick();
        in_data    = 32'h10; tick();
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        #1;
        for (int k = 0; k < 5; k++) begin
            check($sformatf("stall in_ready c%0d", k), in_ready, 0);
            check($sformatf("stall out_valid c%0d", k), out_valid, 1);
            check($sformatf("stall out_data c%0d", k), out_data, 8'h10);
            tick();
        end
        out_ready = 1'b1;
        #1;
        check("resume in_ready", in_ready, 1);
        check("resume beat0", out_data, 8'h10);
        tick();
        check("resume beat1 vld", out_valid, 1);
        check("resume beat1", out_data, 8'h18);
        tick();
        check("resume beat2 vld", out_valid, 1);
        check("resume beat2", out_data, 8'h20);
        tick();
        check("resume drained", out_valid, 0);

        // 1000 random beats under random backpressure against the model.
        cfg_offset = 8'h30;
        sent       = 0;
        recv       = 0;
        cyc        = 0;
        stalled    = 1'b0;
        held_d     = '0;
        held_l     = 1'b0;
        while ((sent < 1000 || sb.size() > 0) && cyc < 20000) begin
            out_ready = 1'($urandom_range(0, 1));
            if (sent < 1000 && $urandom_range(0, 3) != 0) begin
                in_valid = 1'b1;
                in_data  = $urandom >> $urandom_range(0, 31);
                in_last  = ($urandom_range(0, 7) == 0);
            end else begin
                in_valid = 1'b0;
            end
            #4;
            if (stalled) begin
                check("rand hold valid", out_valid, 1);
                check("rand hold data", {out_last, out_data}, {held_l, held_d});
            end
            stalled = out_valid & ~out_ready;
            held_d  = out_data;
            held_l  = out_last;
            if (out_valid & out_ready) begin
                if (sb.size() == 0) begin
                    check("rand no extra beat", out_valid & out_ready, 0);
                end else begin
                    check($sformatf("rand beat #%0d", recv), {out_last, out_data}, sb.pop_front());
                    recv++;
                end
            end
            if (in_valid & in_ready) begin
                sb.push_back({in_last, ref_log(in_data, cfg_offset)});
                sent++;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        in_valid = 1'b0;
        check("rand beats received", recv, 1000);

        // Reset with three beats in flight.
        cfg_offset = 8'h00;
        out_ready  = 1'b1;
        in_valid   = 1'b1;
        in_last    = 1'b1;
        in_data    = 32'h100; tick();
        in_data    = 32'h200; tick();
        in_data    = 32'h400; tick();
        check("pre-reset out_valid", out_valid, 1);
        in_valid = 1'b0;
        rst      = 1'b1;
        tick();
        check("mid reset out_valid", out_valid, 0);
        check("mid reset peak_valid", peak_valid, 0);
        check("mid reset peak_data", peak_data, 0);
        check("mid reset in_ready", in_ready, 1);
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            check($sformatf("post reset out_valid c%0d", k), out_valid, 0);
            check($sformatf("post reset peak_valid c%0d", k), peak_valid, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
